// File: rtl/load_pkg.sv
// Shared load-unit definitions: funct3 load types, fault causes, FSM states
// and the access-size decode.
package load_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110,
    F3_ILL = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_ILLEGAL  = 2'b10
  } cause_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_WAIT0,
    S_REQ1,
    S_WAIT1,
    S_DONE
  } state_e;

  localparam int SIZE_W = 4;

  // funct3[1:0] selects the width; funct3[2] only selects zero extension.
  function automatic logic [SIZE_W-1:0] load_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   load_size = 4'd1;
      2'b01:   load_size = 4'd2;
      2'b10:   load_size = 4'd4;
      default: load_size = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte extraction from a two-beat raw window followed by
// sign or zero extension to XLEN according to funct3.
module load_extend
  import load_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int OFF_W = 3
) (
  input  logic [2*XLEN-1:0] raw,
  input  logic [OFF_W-1:0]  off,
  input  logic [2:0]        funct3,
  output logic [XLEN-1:0]   data
);

  logic [XLEN-1:0]   shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] word_s;

  assign shifted = XLEN'(raw >> {off, 3'b000});
  assign byte_s  = shifted[7:0];
  assign half_s  = shifted[15:0];
  assign word_s  = shifted[31:0];

  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:   data = XLEN'(byte_s);
      F3_LH:   data = XLEN'(half_s);
      F3_LW:   data = XLEN'(word_s);
      F3_LD:   data = shifted;
      F3_LBU:  data = XLEN'(shifted[7:0]);
      F3_LHU:  data = XLEN'(shifted[15:0]);
      F3_LWU:  data = XLEN'(shifted[31:0]);
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: aligned bus reads, two-beat merge for word-crossing
// loads, extension and faulting. Define LOAD_MISALIGN_SPLIT_EN to enable split accesses.
module load_align_unit
  import load_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [RD_W-1:0]   req_rd,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [XLEN-1:0]   wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_fault,
  output logic [1:0]        wb_cause
);

  localparam int BUS_BYTES = XLEN / 8;
  localparam int OFF_W     = $clog2(BUS_BYTES);

`ifdef LOAD_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [RD_W-1:0]   rd_q;
  logic [1:0]        cause_q;
  logic [XLEN-1:0]   beat0_q, beat1_q;
  logic              accept;
  logic              cur_split;
  logic [1:0]        req_cause;
  logic [ADDR_W-1:0] base_addr;
  logic [XLEN-1:0]   ext_data;

  function automatic logic is_illegal(input logic [2:0] f3);
    is_illegal = (f3 == F3_ILL) || ((XLEN == 32) && ((f3 == F3_LD) || (f3 == F3_LWU)));
  endfunction

  function automatic logic crosses_word(input logic [OFF_W-1:0] off, input logic [2:0] f3);
    crosses_word = (int'(off) + int'(load_size(f3))) > BUS_BYTES;
  endfunction

  assign accept    = req_valid && (state == S_IDLE);
  assign cur_split = crosses_word(addr_q[OFF_W-1:0], funct3_q);
  assign base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Faults are resolved at accept so a faulting load never touches the bus.
  always_comb begin
    req_cause = CAUSE_NONE;
    if (is_illegal(req_funct3))
      req_cause = CAUSE_ILLEGAL;
    else if (!SPLIT_EN && crosses_word(req_addr[OFF_W-1:0], req_funct3))
      req_cause = CAUSE_MISALIGN;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid)  state_nxt = (req_cause != CAUSE_NONE) ? S_DONE : S_REQ0;
      S_REQ0:  if (mem_ready)  state_nxt = S_WAIT0;
      S_WAIT0: if (mem_rvalid) state_nxt = cur_split ? S_REQ1 : S_DONE;
      S_REQ1:  if (mem_ready)  state_nxt = S_WAIT1;
      S_WAIT1: if (mem_rvalid) state_nxt = S_DONE;
      S_DONE:  if (wb_ready)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      cause_q  <= '0;
      beat0_q  <= '0;
      beat1_q  <= '0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        rd_q     <= req_rd;
        cause_q  <= req_cause;
        beat0_q  <= '0;
        beat1_q  <= '0;
      end
      if ((state == S_WAIT0) && mem_rvalid) beat0_q <= mem_rdata;
      if ((state == S_WAIT1) && mem_rvalid) beat1_q <= mem_rdata;
    end
  end

  load_extend #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_extend (
    .raw    ({beat1_q, beat0_q}),
    .off    (addr_q[OFF_W-1:0]),
    .funct3 (funct3_q),
    .data   (ext_data)
  );

  always_comb begin
    req_ready = (state == S_IDLE);
    mem_req   = 1'b0;
    mem_addr  = '0;
    wb_valid  = 1'b0;
    wb_data   = '0;
    wb_rd     = '0;
    wb_fault  = 1'b0;
    wb_cause  = 2'b00;
    case (state)
      S_REQ0: begin
        mem_req  = 1'b1;
        mem_addr = base_addr;
      end
      S_REQ1: begin
        mem_req  = 1'b1;
        mem_addr = base_addr + ADDR_W'(BUS_BYTES);
      end
      S_DONE: begin
        wb_valid = 1'b1;
        wb_rd    = rd_q;
        wb_cause = cause_q;
        wb_fault = (cause_q != 2'b00);
        wb_data  = (cause_q != 2'b00) ? '0 : ext_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Randomized bench for load_align_unit against a byte-level reference model;
// follows LOAD_MISALIGN_SPLIT_EN to select the expected split behaviour.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ready, mem_rvalid;
  logic [63:0] mem_rdata;
  logic        wb_valid, wb_ready;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_fault;
  logic [1:0]  wb_cause;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_align_unit #(.XLEN(64), .ADDR_W(64), .RD_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_rd(req_rd),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_fault(wb_fault), .wb_cause(wb_cause)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_split(input logic [63:0] a, input logic [2:0] f3);
    return (int'(a % 64'd8) + size_of(f3)) > 8;
  endfunction

  function automatic logic [1:0] ref_cause(input logic [63:0] a, input logic [2:0] f3);
    if (f3 == 3'b111) return 2'b10;
`ifndef LOAD_MISALIGN_SPLIT_EN
    if (ref_split(a, f3)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  // Assemble the loaded value byte by byte from a 16-byte little-endian window.
  function automatic logic [63:0] ref_value(input logic [63:0] a, input logic [2:0] f3,
                                            input logic [63:0] w0, input logic [63:0] w1);
    logic [7:0]  mem [16];
    logic [63:0] v;
    int          off;
    int          sz;
    off = int'(a % 64'd8);
    sz  = size_of(f3);
    v   = '0;
    for (int i = 0; i < 8; i++) begin
      mem[i]     = w0[8*i +: 8];
      mem[i + 8] = w1[8*i +: 8];
    end
    for (int i = 0; i < sz; i++) v = v | (64'(mem[off + i]) << (8 * i));
    if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ~((64'd1 << (8 * sz)) - 64'd1);
    return v;
  endfunction

  task automatic do_load(input logic [63:0] a, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [63:0] w0, input logic [63:0] w1,
                         input int dmax, input int hold, output logic [63:0] got);
    logic [1:0]  ecause;
    logic [63:0] edata, exp_addr;
    bit          split;
    int          nb, acc, elat, d1, d2, t;
    ecause = ref_cause(a, f3);
    split  = ref_split(a, f3);
    nb     = (ecause != 2'b00) ? 0 : (split ? 2 : 1);
    edata  = (ecause != 2'b00) ? 64'd0 : ref_value(a, f3, w0, split ? w1 : 64'd0);
    got    = '0;
    @(negedge clk);
    check_val("req_ready_idle", req_ready, 1);
    req_valid = 1; req_addr = a; req_funct3 = f3; req_rd = rd;
    @(posedge clk); #1;
    acc = cyc;
    @(negedge clk);
    req_valid = 0; req_addr = {$urandom, $urandom}; req_funct3 = 3'($urandom_range(7, 0));
    elat = 1;
    if (nb == 0) check_val("fault_no_mem_req", mem_req, 0);
    for (int b = 0; b < nb; b++) begin
      exp_addr = (a & ~64'd7) + 64'(8 * b);
      check_val("mem_req", mem_req, 1);
      check_val("mem_addr", mem_addr, exp_addr);
      d1 = $urandom_range(dmax, 0);
      d2 = $urandom_range(dmax, 0);
      repeat (d1) begin
        mem_rvalid = 1'($urandom_range(1, 0)); mem_rdata = {$urandom, $urandom};
        @(negedge clk);
        mem_rvalid = 0;
      end
      mem_ready = 1;
      @(negedge clk);
      mem_ready = 0;
      check_val("mem_req_drop", mem_req, 0);
      repeat (d2) @(negedge clk);
      mem_rvalid = 1; mem_rdata = (b == 0) ? w0 : w1;
      @(negedge clk);
      mem_rvalid = 0; mem_rdata = {$urandom, $urandom};
      elat += 2 + d1 + d2;
    end
    t = 0;
    while (!wb_valid && t < 50) begin @(negedge clk); t++; end
    check_val("wb_valid_seen", wb_valid, 1);
    check_val("latency", 64'(cyc - acc + 1), 64'(elat));
    got = wb_data;
    for (int h = 0; h <= hold; h++) begin
      check_val("wb_valid_hold", wb_valid, 1);
      check_val("wb_data", wb_data, edata);
      check_val("wb_rd", wb_rd, rd);
      check_val("wb_fault", wb_fault, ecause != 2'b00);
      check_val("wb_cause", wb_cause, ecause);
      check_val("req_ready_busy", req_ready, 0);
      if (h < hold) begin
        mem_rvalid = 1'($urandom_range(1, 0)); mem_rdata = {$urandom, $urandom};
        @(negedge clk);
        mem_rvalid = 0;
      end
    end
    wb_ready = 1;
    @(negedge clk);
    wb_ready = 0;
    check_val("wb_valid_drop", wb_valid, 0);
    check_val("req_ready_back", req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] got, a;
    logic [2:0]  f3;
    reset = 1; req_valid = 0; req_addr = '0; req_funct3 = '0; req_rd = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0; wb_ready = 0;
    repeat (3) @(negedge clk);
    check_val("rst_req_ready", req_ready, 1);
    check_val("rst_mem_req", mem_req, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_wb_valid", wb_valid, 0);
    check_val("rst_wb_data", wb_data, 0);
    check_val("rst_wb_rd", wb_rd, 0);
    check_val("rst_wb_fault", wb_fault, 0);
    check_val("rst_wb_cause", wb_cause, 0);
    reset = 0;

    do_load(64'h1003, 3'b000, 5'd1, 64'h0000_0000_8000_0000, 64'd0, 0, 0, got);
    check_val("lb_1003", got, 64'hFFFF_FFFF_FFFF_FF80);
    do_load(64'h2000, 3'b100, 5'd2, '1, 64'd0, 0, 0, got);
    check_val("lbu_2000", got, 64'h0000_0000_0000_00FF);
    do_load(64'h2000, 3'b101, 5'd3, '1, 64'd0, 0, 0, got);
    check_val("lhu_2000", got, 64'h0000_0000_0000_FFFF);
    do_load(64'h2000, 3'b110, 5'd4, '1, 64'd0, 0, 0, got);
    check_val("lwu_2000", got, 64'h0000_0000_FFFF_FFFF);
    do_load(64'h3006, 3'b011, 5'd5, 64'hBBAA_0000_0000_0000, 64'h0000_0000_0000_DDCC, 0, 0, got);
`ifdef LOAD_MISALIGN_SPLIT_EN
    check_val("ld_3006_split", got, 64'h0000_0000_DDCC_BBAA);
`else
    check_val("ld_3006_fault", got, 64'd0);
`endif
    do_load(64'h5000, 3'b111, 5'd6, 64'd0, 64'd0, 0, 5, got);
    check_val("ill_data", got, 64'd0);

    // Abort in WAIT0, then a stale response after reset.
    @(negedge clk);
    req_valid = 1; req_addr = 64'h4000; req_funct3 = 3'b011; req_rd = 5'd7;
    @(negedge clk);
    req_valid = 0; mem_ready = 1;
    @(negedge clk);
    mem_ready = 0; reset = 1;
    @(negedge clk);
    reset = 0; mem_rvalid = 1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    mem_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      check_val("abort_wb_valid", wb_valid, 0);
      check_val("abort_req_ready", req_ready, 1);
      check_val("abort_mem_req", mem_req, 0);
      @(negedge clk);
    end

    for (int n = 0; n < 150; n++) begin
      a  = (n % 8 == 7) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0)))
                        : {32'd0, $urandom};
      f3 = 3'($urandom_range(7, 0));
      do_load(a, f3, 5'($urandom_range(31, 0)), {$urandom, $urandom}, {$urandom, $urandom},
              2, $urandom_range(2, 0), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
